jtag_tap_responder: RTL and testbench

- JTAG target-side TAP controller: the device end of the TCK/TMS/TDI/TDO link that the board translator drives from the host.
- Oversamples the JTAG pins in the system clock domain (SB_HFOSC-derived `clk`) and runs the IEEE 1149.1 16-state TAP machine.
- Implements IDCODE and BYPASS, plus an optional 32-bit USER data register, and drives TDO back to the translator.
- Used for on-board loopback testing of the translator and as a debug port into fabric logic.

---
 rtl/jtag_tap_responder.sv | 188 ++++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: device-side IEEE 1149.1 TAP controller, oversampled in clk.
// Provides IDCODE and BYPASS. The optional 32-bit USER data register is
// built only when the JTAG_TAP_USER_EN macro is defined. Without it, code 4'h8
// decodes as BYPASS and the USER outputs are tied low.
module jtag_tap_responder #(
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int          IR_LEN      = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tck_i,
  input  logic        tms_i,
  input  logic        tdi_i,
  output logic        tdo_o,
  output logic        tdo_oe_o,
  output logic [3:0]  tap_state_o,
  output logic        tlr_o,
  input  logic [31:0] user_din_i,
  output logic [31:0] user_dout_o,
  output logic        user_update_o
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,
    EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12,
    PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

  logic [SYNC_STAGES-1:0] tck_sync_p0, tms_sync_p0, tdi_sync_p0;
  logic                   tck_prev_p1;
  logic                   tck_s, tms_s, tdi_s;
  logic                   tck_rise, tck_fall;

  tap_state_t        state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_shift_q;
  logic [31:0]       dr_shift_q;
  logic              bypass_q;
  logic              sel_idcode, sel_user, sel_bypass;

  // Pin synchronizers: equal depth keeps TCK, TMS and TDI aligned in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_p0 <= '0;
      tms_sync_p0 <= '0;
      tdi_sync_p0 <= '0;
      tck_prev_p1 <= 1'b0;
    end else begin
      tck_sync_p0 <= {tck_sync_p0[SYNC_STAGES-2:0], tck_i};
      tms_sync_p0 <= {tms_sync_p0[SYNC_STAGES-2:0], tms_i};
      tdi_sync_p0 <= {tdi_sync_p0[SYNC_STAGES-2:0], tdi_i};
      tck_prev_p1 <= tck_sync_p0[SYNC_STAGES-1];
    end
  end

  assign tck_s    = tck_sync_p0[SYNC_STAGES-1];
  assign tms_s    = tms_sync_p0[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_p0[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_p1;
  assign tck_fall = ~tck_s & tck_prev_p1;

  // Instruction decode; anything unrecognised falls back to BYPASS.
  assign sel_idcode = (ir_q == IR_IDCODE);
`ifdef JTAG_TAP_USER_EN
  localparam logic [IR_LEN-1:0] IR_USER = IR_LEN'(8);
  assign sel_user   = (ir_q == IR_USER);
`else
  assign sel_user   = 1'b0;
`endif
  assign sel_bypass = ~sel_idcode & ~sel_user;

  // TAP state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_d;
  end

  // TAP next-state graph, advanced only in a TCK-rise cycle.
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:      state_d = tms_s ? TLR      : RTI;
        RTI:      state_d = tms_s ? SEL_DR   : RTI;
        SEL_DR:   state_d = tms_s ? SEL_IR   : CAP_DR;
        CAP_DR:   state_d = tms_s ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_d = tms_s ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_d = tms_s ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_d = tms_s ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_d = tms_s ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_d = tms_s ? SEL_DR   : RTI;
        SEL_IR:   state_d = tms_s ? TLR      : CAP_IR;
        CAP_IR:   state_d = tms_s ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_d = tms_s ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_d = tms_s ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_d = tms_s ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_d = tms_s ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_d = tms_s ? SEL_DR   : RTI;
        default:  state_d = TLR;
      endcase
    end
  end

  // Capture/shift/update actions keyed on the state before the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
      dr_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else if (tck_rise) begin
      case (state_q)
        TLR:      ir_q       <= IR_IDCODE;
        CAP_IR:   ir_shift_q <= IR_CAPTURE;
        SHIFT_IR: ir_shift_q <= {tdi_s, ir_shift_q[IR_LEN-1:1]};
        UPD_IR:   ir_q       <= ir_shift_q;
        CAP_DR: begin
          bypass_q <= 1'b0;
          if (sel_idcode) dr_shift_q <= IDCODE_VAL;
`ifdef JTAG_TAP_USER_EN
          else if (sel_user) dr_shift_q <= user_din_i;
`endif
        end
        SHIFT_DR: begin
          if (sel_bypass) bypass_q   <= tdi_s;
          else            dr_shift_q <= {tdi_s, dr_shift_q[31:1]};
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_TAP_USER_EN
  // USER parallel output: latched and strobed for one clk on Update-DR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_dout_o   <= '0;
      user_update_o <= 1'b0;
    end else begin
      user_update_o <= tck_rise && (state_q == UPD_DR) && sel_user;
      if (tck_rise && (state_q == UPD_DR) && sel_user) user_dout_o <= dr_shift_q;
    end
  end
`else
  logic unused_user_din;
  assign unused_user_din = ^user_din_i;
  assign user_dout_o     = '0;
  assign user_update_o   = 1'b0;
`endif

  // TDO launch on TCK fall; the enable follows the post-rise shift states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else if (tck_fall) begin
      if (state_q == SHIFT_IR) begin
        tdo_o    <= ir_shift_q[0];
        tdo_oe_o <= 1'b1;
      end else if (state_q == SHIFT_DR) begin
        tdo_o    <= sel_bypass ? bypass_q : dr_shift_q[0];
        tdo_oe_o <= 1'b1;
      end else begin
        tdo_oe_o <= 1'b0;
      end
    end
  end

  assign tap_state_o = state_q;
  assign tlr_o       = (state_q == TLR);

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed and randomized JTAG sequences against a
// queue-based TAP reference model.
module tb_jtag_tap_responder;

  localparam int          SYNC = 2;
  localparam int          HALF = 6;
  localparam logic [31:0] IDV  = 32'h1000_0001;
`ifdef JTAG_TAP_USER_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tck_i, tms_i, tdi_i;
  logic        tdo_o, tdo_oe_o, tlr_o, user_update_o;
  logic [3:0]  tap_state_o;
  logic [31:0] user_din_i, user_dout_o;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // reference model state
  int          m_state;
  int          m_ir;
  bit          irq[$];
  bit          drq[$];
  bit          m_tdo;
  logic [31:0] m_user;
  int          exp_pulses;
  int          n0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int          n1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  jtag_tap_responder #(.IDCODE_VAL(IDV), .IR_LEN(4), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .tap_state_o(tap_state_o), .tlr_o(tlr_o),
    .user_din_i(user_din_i), .user_dout_o(user_dout_o), .user_update_o(user_update_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (user_update_o === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sel_kind();  // 0 idcode, 1 bypass, 2 user
    if (m_ir == 1) return 0;
    if (m_ir == 8 && USER_EN) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ir = 1; irq = {}; drq = {}; m_tdo = 1'b0; m_user = '0;
  endtask

  task automatic model_rise(input bit tms, input bit tdi);
    logic [31:0] v;
    case (m_state)
      0:  m_ir = 1;
      10: begin irq = {}; irq.push_back(1'b1); for (int i = 1; i < 4; i++) irq.push_back(1'b0); end
      11: begin void'(irq.pop_front()); irq.push_back(tdi); end
      15: begin m_ir = 0; for (int i = 0; i < 4; i++) m_ir += int'(irq[i]) << i; end
      3: begin
        drq = {};
        if (sel_kind() == 1) drq.push_back(1'b0);
        else begin
          v = (sel_kind() == 0) ? IDV : user_din_i;
          for (int i = 0; i < 32; i++) drq.push_back(v[i]);
        end
      end
      4:  begin void'(drq.pop_front()); drq.push_back(tdi); end
      8: if (sel_kind() == 2) begin
        for (int i = 0; i < 32; i++) m_user[i] = drq[i];
        exp_pulses++;
      end
      default: ;
    endcase
    m_state = tms ? n1[m_state] : n0[m_state];
  endtask

  task automatic model_fall();
    if (m_state == 11) m_tdo = irq[0];
    if (m_state == 4)  m_tdo = drq[0];
  endtask

  task automatic check_all();
    chk("state", tap_state_o, m_state);
    chk("tlr", tlr_o, (m_state == 0));
    chk("tdo_oe", tdo_oe_o, (m_state == 4 || m_state == 11));
    chk("tdo", tdo_o, m_tdo);
    chk("user_dout", user_dout_o, m_user);
    chk("user_pulses", pulse_cnt, exp_pulses);
  endtask

  task automatic tck_cycle(input bit tms, input bit tdi);
    int prev;
    tms_i = tms; tdi_i = tdi;
    repeat (HALF) @(negedge clk);
    prev = m_state;
    model_rise(tms, tdi);
    tck_i = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("lat_hold", tap_state_o, prev);
    @(negedge clk);
    chk("lat_move", tap_state_o, m_state);
    repeat (HALF - SYNC - 1) @(negedge clk);
    tck_i = 1'b0;
    model_fall();
    repeat (HALF) @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic goto_shift_dr();  // from RTI
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
  endtask

  task automatic goto_shift_ir();  // from RTI
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
  endtask

  // From a shift state: shift n bits, sample TDO before each rise, end in RTI.
  task automatic scan(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo_o;
      tck_cycle(i == n - 1, din[i]);
    end
    tck_cycle(1, 0);
    tck_cycle(0, 0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] rdat;
    int          exp_seq[5];
    exp_seq = '{5, 8, 2, 9, 0};
    rst_n = 1'b0; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; user_din_i = '0;
    exp_pulses = 0;
    model_reset();
    repeat (4) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // TLR hold with TMS high
    for (int i = 0; i < 6; i++) tck_cycle(1, 0);
    chk("tlr_hold_state", tap_state_o, 4'd0);

    // IDCODE read
    tck_cycle(0, 0);
    goto_shift_dr();
    scan(32'h0, 32, got);
    chk("idcode_word", got, IDV);

    // IR scan BYPASS, then bypass DR scan
    goto_shift_ir();
    scan(32'hF, 4, got);
    chk("ir_capture", got, 32'h1);
    goto_shift_dr();
    scan(32'h0000_000D, 5, got);
    chk("bypass_delay", got, 32'h0000_001A);

    // Five TMS-high rises from SHIFT_DR reach TLR
    goto_shift_dr();
    for (int i = 0; i < 5; i++) begin
      tck_cycle(1, 1);
      chk("tms5_seq", tap_state_o, exp_seq[i]);
    end
    tck_cycle(0, 0);
    goto_shift_dr();
    scan($urandom, 32, got);
    chk("idcode_after_tlr", got, IDV);

    // USER scan
    user_din_i = 32'hCAFE_0001;
    goto_shift_ir();
    scan(32'h8, 4, got);
    goto_shift_dr();
    scan(32'h1234_5678, 32, got);
    chk("user_tdo", got, USER_EN ? 32'hCAFE_0001 : 32'h2468_ACF0);
    chk("user_dout", user_dout_o, USER_EN ? 32'h1234_5678 : 32'h0);
    chk("user_pulse_total", pulse_cnt, USER_EN ? 1 : 0);

    // Reset in the middle of a USER shift
    goto_shift_dr();
    for (int i = 0; i < 10; i++) tck_cycle(0, $urandom_range(0, 1));
    do_reset();
    chk("abort_dout", user_dout_o, 32'h0);
    chk("abort_pulses", pulse_cnt, USER_EN ? 1 : 0);
    tck_cycle(0, 0);
    goto_shift_dr();
    scan(32'h0, 32, got);
    chk("idcode_after_abort", got, IDV);

    // Random TMS/TDI walk through the whole graph
    for (int i = 0; i < 250; i++) begin
      user_din_i = $urandom;
      tck_cycle($urandom_range(0, 99) < 35, $urandom_range(0, 1));
    end

    // Random IR code then random DR data, from a known start
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) tck_cycle(1, 0);
      tck_cycle(0, 0);
      goto_shift_ir();
      rdat = (k == 0) ? 32'h8 : 32'($urandom_range(0, 15));
      scan(rdat, 4, got);
      user_din_i = $urandom;
      goto_shift_dr();
      scan($urandom, 32, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
